// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types and constants.
// Sizes the scoreboard counters, IDs and writeback bundles.
package fpu_ss_pkg;

  localparam int unsigned NB_CORES = 8;
  localparam int unsigned NB_REGS = 32;
  localparam int unsigned MAX_PENDING = 3;
  localparam int unsigned NB_IDS = 16;
  localparam int unsigned MAX_MEM_OUTSTANDING = 4;

  localparam int unsigned SB_CORE_W = $clog2(NB_CORES);
  localparam int unsigned SB_ID_W = $clog2(NB_IDS);
  localparam int unsigned SB_CNT_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned SB_MEM_W = $clog2(MAX_MEM_OUTSTANDING + 1);

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic                 valid;
    logic [SB_CORE_W-1:0] core_id;
    logic [4:0]           rd;
    logic                 is_fp;
  } sb_wb_t;

  function automatic logic sb_hit(
    sb_wb_t               w,
    logic [SB_CORE_W-1:0] core,
    logic [4:0]           rd
  );
    return w.valid & w.is_fp & (w.core_id == core) & (w.rd == rd);
  endfunction

endpackage

// File: rtl/fpu_ss_scoreboard_if.sv
// Issue, writeback and commit bundle of the FPU scoreboard.
// The dispatch side is master; the scoreboard is slave.
interface fpu_ss_scoreboard_if;
  import fpu_ss_pkg::*;

  logic                 iss_valid_i;
  logic [SB_CORE_W-1:0] iss_core_id_i;
  logic [SB_ID_W-1:0]   iss_id_i;
  logic [2:0][4:0]      iss_rs_i;
  logic [2:0]           iss_rs_used_i;
  logic [4:0]           iss_rd_i;
  logic                 iss_rd_is_fp_i;
  logic                 iss_is_mem_i;
  logic                 iss_fire_i;
  logic                 iss_stall_o;
  logic                 iss_committed_o;
  logic [2:0]           fwd_fpu_o;
  logic [2:0]           fwd_lsu_o;
  logic                 fpu_wb_valid_i;
  logic [SB_CORE_W-1:0] fpu_wb_core_id_i;
  logic [4:0]           fpu_wb_rd_i;
  logic                 fpu_wb_is_fp_i;
  logic [SB_ID_W-1:0]   fpu_wb_id_i;
  logic                 mem_req_hs_i;
  logic                 mem_res_valid_i;
  logic [SB_CORE_W-1:0] mem_res_core_id_i;
  logic [4:0]           mem_res_rd_i;
  logic                 mem_res_we_i;
  logic                 commit_valid_i;
  logic [SB_ID_W-1:0]   commit_id_i;
  logic                 commit_kill_i;
  logic                 mem_credit_o;
  logic                 err_o;
  logic [31:0]          stall_cnt_o;
  logic [31:0]          fwd_cnt_o;

  modport master (
    output iss_valid_i, iss_core_id_i, iss_id_i, iss_rs_i,
    output iss_rs_used_i, iss_rd_i, iss_rd_is_fp_i,
    output iss_is_mem_i, iss_fire_i,
    output fpu_wb_valid_i, fpu_wb_core_id_i, fpu_wb_rd_i,
    output fpu_wb_is_fp_i, fpu_wb_id_i,
    output mem_req_hs_i, mem_res_valid_i, mem_res_core_id_i,
    output mem_res_rd_i, mem_res_we_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  iss_stall_o, iss_committed_o, fwd_fpu_o, fwd_lsu_o,
    input  mem_credit_o, err_o, stall_cnt_o, fwd_cnt_o
  );

  modport slave (
    input  iss_valid_i, iss_core_id_i, iss_id_i, iss_rs_i,
    input  iss_rs_used_i, iss_rd_i, iss_rd_is_fp_i,
    input  iss_is_mem_i, iss_fire_i,
    input  fpu_wb_valid_i, fpu_wb_core_id_i, fpu_wb_rd_i,
    input  fpu_wb_is_fp_i, fpu_wb_id_i,
    input  mem_req_hs_i, mem_res_valid_i, mem_res_core_id_i,
    input  mem_res_rd_i, mem_res_we_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output iss_stall_o, iss_committed_o, fwd_fpu_o, fwd_lsu_o,
    output mem_credit_o, err_o, stall_cnt_o, fwd_cnt_o
  );

endinterface

// File: rtl/fpu_ss_sat_counter.sv
// Up/down counter clamped to [0, MAX].
// err_o pulses in any cycle an update would leave that range.
module fpu_ss_sat_counter #(
  parameter int unsigned W = 3,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX) err_o = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fpu_ss_scoreboard.sv
// Multi-core pending-write scoreboard for the shared FPU.
// FPU_SS_SB_STATS_EN adds stall and forward cycle counters.
module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter bit FORWARDING = 1'b1
) (
  input logic                clk_i,
  input logic                rst_ni,
  fpu_ss_scoreboard_if.slave sb
);

  localparam logic signed [SB_CNT_W+1:0] S_ONE = 1;
  localparam logic signed [SB_CNT_W+1:0] S_MAX = MAX_PENDING;

  sb_cnt_t cnt_q [NB_CORES][NB_REGS];
  sb_cnt_t cnt_d [NB_CORES][NB_REGS];
  logic signed [SB_CNT_W+1:0] sum;
  logic pend_err, mem_err, err_q;
  logic [NB_IDS-1:0] id_q, id_d;
  logic [SB_MEM_W-1:0] mem_cnt;
  sb_wb_t iss_wb, fpu_wb, lsu_wb;
  logic [2:0] dep, fwd_f, fwd_l;
  logic rd_full, rd_dec;

  assign iss_wb = '{sb.iss_fire_i, sb.iss_core_id_i,
                    sb.iss_rd_i, sb.iss_rd_is_fp_i};
  assign fpu_wb = '{sb.fpu_wb_valid_i, sb.fpu_wb_core_id_i,
                    sb.fpu_wb_rd_i, sb.fpu_wb_is_fp_i};
  assign lsu_wb = '{sb.mem_res_valid_i & sb.mem_res_we_i,
                    sb.mem_res_core_id_i, sb.mem_res_rd_i, 1'b1};

  // Net update per (core, reg): range -2..+1, clamped with error.
  always_comb begin
    cnt_d = cnt_q;
    pend_err = 1'b0;
    sum = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      for (int r = 0; r < NB_REGS; r++) begin
        sum = {2'b00, cnt_q[c][r]};
        if (sb_hit(iss_wb, SB_CORE_W'(c), 5'(r))) sum = sum + S_ONE;
        if (sb_hit(fpu_wb, SB_CORE_W'(c), 5'(r))) sum = sum - S_ONE;
        if (sb_hit(lsu_wb, SB_CORE_W'(c), 5'(r))) sum = sum - S_ONE;
        if (sum[SB_CNT_W+1]) begin
          cnt_d[c][r] = '0;
          pend_err = 1'b1;
        end else if (sum > S_MAX) begin
          pend_err = 1'b1;
        end else begin
          cnt_d[c][r] = sum[SB_CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CORES; c++)
        for (int r = 0; r < NB_REGS; r++)
          cnt_q[c][r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    fwd_f = '0;
    fwd_l = '0;
    dep = '0;
    for (int k = 0; k < 3; k++) begin
      if (sb.iss_rs_used_i[k] &&
          cnt_q[sb.iss_core_id_i][sb.iss_rs_i[k]] == sb_cnt_t'(1)) begin
        fwd_f[k] = FORWARDING &
                   sb_hit(fpu_wb, sb.iss_core_id_i, sb.iss_rs_i[k]);
        fwd_l[k] = FORWARDING & ~fwd_f[k] &
                   sb_hit(lsu_wb, sb.iss_core_id_i, sb.iss_rs_i[k]);
      end
      dep[k] = sb.iss_rs_used_i[k] &
               (cnt_q[sb.iss_core_id_i][sb.iss_rs_i[k]] != '0) &
               ~fwd_f[k] & ~fwd_l[k];
    end
  end

  assign rd_dec = sb_hit(fpu_wb, sb.iss_core_id_i, sb.iss_rd_i) |
                  sb_hit(lsu_wb, sb.iss_core_id_i, sb.iss_rd_i);
  assign rd_full = sb.iss_rd_is_fp_i & ~rd_dec &
    (cnt_q[sb.iss_core_id_i][sb.iss_rd_i] == sb_cnt_t'(MAX_PENDING));

  assign sb.fwd_fpu_o = fwd_f;
  assign sb.fwd_lsu_o = fwd_l;
  assign sb.mem_credit_o = mem_cnt < SB_MEM_W'(MAX_MEM_OUTSTANDING);
  assign sb.iss_stall_o = sb.iss_valid_i & ((|dep) | rd_full |
                          (sb.iss_is_mem_i & ~sb.mem_credit_o));

  fpu_ss_sat_counter #(
    .W   (SB_MEM_W),
    .MAX (SB_MEM_W'(MAX_MEM_OUTSTANDING))
  ) i_mem_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (sb.mem_req_hs_i),
    .dec_i  (sb.mem_res_valid_i),
    .cnt_o  (mem_cnt),
    .err_o  (mem_err)
  );

  // Commit sets after any clear so a same-cycle commit wins.
  always_comb begin
    id_d = id_q;
    if (sb.fpu_wb_valid_i) id_d[sb.fpu_wb_id_i] = 1'b0;
    if (sb.commit_valid_i) id_d[sb.commit_id_i] = ~sb.commit_kill_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q <= '0;
      err_q <= 1'b0;
    end else begin
      id_q <= id_d;
      err_q <= err_q | pend_err | mem_err;
    end
  end

  assign sb.err_o = err_q;
  assign sb.iss_committed_o = id_q[sb.iss_id_i] |
    (sb.commit_valid_i & ~sb.commit_kill_i &
     (sb.commit_id_i == sb.iss_id_i));

`ifdef FPU_SS_SB_STATS_EN
  logic unused_stall_sat, unused_fwd_sat;

  fpu_ss_sat_counter #(.W(32), .MAX('1)) i_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (sb.iss_valid_i & sb.iss_stall_o),
    .dec_i  (1'b0),
    .cnt_o  (sb.stall_cnt_o),
    .err_o  (unused_stall_sat)
  );

  fpu_ss_sat_counter #(.W(32), .MAX('1)) i_fwd_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (|{fwd_f, fwd_l}),
    .dec_i  (1'b0),
    .cnt_o  (sb.fwd_cnt_o),
    .err_o  (unused_fwd_sat)
  );
`else
  assign sb.stall_cnt_o = '0;
  assign sb.fwd_cnt_o = '0;
`endif

endmodule
